// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {READY = 1'b0, FILL = 1'b1} statetype;

  // Widest line the word extractor accepts (64 words of 32 bits).
  localparam int MAX_LINE_W = 2048;

  function automatic int ob_bits(input int bs);
    return $clog2(bs) + 2;
  endfunction

  function automatic int ib_bits(input int ln);
    return $clog2(ln);
  endfunction

  function automatic int tb_bits(input int bs, input int ln);
    return 32 - ob_bits(bs) - ib_bits(ln);
  endfunction

  // Word 0 sits in the MSBs of a line, so word w starts (bs-1-w) words up.
  function automatic logic [31:0] get_word(input logic [MAX_LINE_W-1:0] line,
                                           input int bs, input int w);
    logic [MAX_LINE_W-1:0] sh;
    sh = line >> ((bs - 1 - w) * 32);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, single line write, async valid clear.
module icache_array
  import icache_pkg::*;
#(
  parameter int blocksize = 4,
  parameter int lines     = 16,
  localparam int IB = ib_bits(lines),
  localparam int TB = tb_bits(blocksize, lines),
  localparam int LW = blocksize * 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IB-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TB-1:0] rd_tag,
  output logic [LW-1:0] rd_line,
  input  logic          we,
  input  logic [IB-1:0] wr_idx,
  input  logic [TB-1:0] wr_tag,
  input  logic [LW-1:0] wr_line
);

  logic [lines-1:0] valid;
  logic [TB-1:0]    tags [lines];
  logic [LW-1:0]    data [lines];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid         <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  // Tag and data carry no reset; the valid bit gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = data[rd_idx];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped I-cache with block-read line fill. Define ICACHE_STATS_EN to add
// saturating HitCnt/MissCnt outputs.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int blocksize = 4,
  parameter int lines     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [31:0]             PCF,
  output logic [31:0]             InstrF,
  output logic                    Stall,
  output logic                    MemRE,
  output logic [31:0]             MemA,
  input  logic [blocksize*32-1:0] MemRD,
  input  logic                    MemValid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             HitCnt,
  output logic [31:0]             MissCnt
`endif
);

  localparam int OB = ob_bits(blocksize);
  localparam int IB = ib_bits(lines);
  localparam int TB = tb_bits(blocksize, lines);
  localparam int LW = blocksize * 32;

  statetype      state, state_n;
  logic [31:0]   miss_addr;
  logic          miss_load, fill_done, hit;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic [OB-3:0] word;
  logic          rd_valid;
  logic [TB-1:0] rd_tag;
  logic [LW-1:0] rd_line;
  logic          unused_pcf;

  assign idx        = PCF[OB+IB-1:OB];
  assign tag        = PCF[31:OB+IB];
  assign word       = PCF[OB-1:2];
  assign unused_pcf = ^PCF[1:0];

  icache_array #(.blocksize(blocksize), .lines(lines)) u_array (
    .clk      (clk),
    .rst_n    (reset),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (fill_done),
    .wr_idx   (miss_addr[OB+IB-1:OB]),
    .wr_tag   (miss_addr[31:OB+IB]),
    .wr_line  (MemRD)
  );

  assign hit    = en & rd_valid & (rd_tag == tag);
  assign InstrF = hit ? get_word(MAX_LINE_W'(rd_line), blocksize, int'(word)) : '0;
  assign MemA   = miss_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= READY;
      miss_addr <= '0;
    end else begin
      state <= state_n;
      if (miss_load) miss_addr <= {PCF[31:OB], {OB{1'b0}}};
    end
  end

  always_comb begin
    state_n   = state;
    Stall     = 1'b0;
    MemRE     = 1'b0;
    miss_load = 1'b0;
    fill_done = 1'b0;
    case (state)
      READY: if (en && !hit) begin
        Stall     = 1'b1;
        miss_load = 1'b1;
        state_n   = FILL;
      end
      FILL: begin
        Stall = 1'b1;
        MemRE = 1'b1;
        if (MemValid) begin
          fill_done = 1'b1;
          state_n   = READY;
        end
      end
      default: state_n = READY;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HitCnt  <= '0;
      MissCnt <= '0;
    end else begin
      if (state == READY && hit && HitCnt != '1)  HitCnt  <= HitCnt + 32'd1;
      if (miss_load && MissCnt != '1)             MissCnt <= MissCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios plus random fetch traffic checked
// against an address-level cache model and a latency-programmable memory responder.
module tb_icache_fill_ctrl;

  localparam int BS = 4;
  localparam int LN = 16;
  localparam int OB = 4;
  localparam int IB = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en = 1'b0;
  logic [31:0]    PCF = '0;
  logic [BS*32-1:0] MemRD = '0;
  logic           MemValid = 1'b0;
  logic [31:0]    InstrF, MemA;
  logic           Stall, MemRE;
`ifdef ICACHE_STATS_EN
  logic [31:0]    HitCnt, MissCnt;
`endif

  int vec = 0, errs = 0;

  // responder controls
  bit resp_en = 1'b1, man_mv = 1'b0, rand_lat = 1'b0;
  int lat = 2, rcnt = 0;

  // reference model: which memory line each index holds, and the outstanding fill
  bit          m_valid [LN];
  logic [31:0] m_tag   [LN];
  bit          m_fill;
  logic [31:0] m_addr;

  logic        exp_stall, exp_re, exp_ichk;
  logic [31:0] exp_a, exp_instr;

  icache_fill_ctrl #(.blocksize(BS), .lines(LN)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .PCF      (PCF),
    .InstrF   (InstrF),
    .Stall    (Stall),
    .MemRE    (MemRE),
    .MemA     (MemA),
    .MemRD    (MemRD),
    .MemValid (MemValid)
`ifdef ICACHE_STATS_EN
    ,
    .HitCnt   (HitCnt),
    .MissCnt  (MissCnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: word at 0x100 is 0xA0, 0x104 is 0xA1, ... and unique everywhere.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a >> 2) ^ 32'hE0;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> OB) % LN);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == (a >> (OB + IB)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LN; i++) m_valid[i] = 1'b0;
    m_fill = 1'b0;
    m_addr = '0;
  endtask

  // Block-read responder: answers after `lat` cycles of MemRE with the line at MemA.
  always @(negedge clk) begin
    if (!resp_en) begin
      MemValid = man_mv;
    end else if (MemValid) begin
      MemValid = 1'b0;
      rcnt     = 0;
    end else if (MemRE) begin
      rcnt++;
      if (rcnt >= lat) begin
        MemValid = 1'b1;
        for (int w = 0; w < BS; w++) MemRD[(BS-1-w)*32 +: 32] = memw(MemA + 32'(4 * w));
        if (rand_lat) lat = $urandom_range(1, 4);
      end
    end else begin
      rcnt = 0;
    end
  end

  // Apply one fetch cycle, capture expectations, then advance the model past the edge.
  task automatic drive(input bit e, input logic [31:0] pc);
    @(negedge clk);
    en  = e;
    PCF = pc;
    #1;
    exp_stall = m_fill || (e && !m_hit(pc));
    exp_re    = m_fill;
    exp_a     = m_addr;
    exp_ichk  = e && !exp_stall;
    exp_instr = memw({pc[31:2], 2'b00});
    if (m_fill) begin
      if (MemValid) begin
        m_valid[idx_of(m_addr)] = 1'b1;
        m_tag[idx_of(m_addr)]   = m_addr >> (OB + IB);
        m_fill = 1'b0;
      end
    end else if (e && !m_hit(pc)) begin
      m_fill = 1'b1;
      m_addr = (pc >> OB) << OB;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Miss on pc and keep fetching it until it hits; every cycle is checked.
  task automatic fill_line(input logic [31:0] pc, input string nm);
    bit done = 1'b0;
    drive(1'b1, pc);
    vec++;
    if (Stall !== 1'b1) begin errs++; $display("FAIL %s first_miss got stall=%b exp 1", nm, Stall); end
    for (int i = 0; i < 30 && !done; i++) begin
      if (i > 0) drive(1'b1, pc);
      vec++;
      if ({Stall, MemRE, MemA} !== {exp_stall, exp_re, exp_a}) begin
        errs++;
        $display("FAIL %s ctl pc=%h got stall=%b re=%b a=%h exp %b %b %h", nm, pc, Stall, MemRE, MemA, exp_stall, exp_re, exp_a);
      end
      if (exp_ichk) begin
        vec++;
        if (InstrF !== exp_instr) begin errs++; $display("FAIL %s instr pc=%h got %h exp %h", nm, pc, InstrF, exp_instr); end
      end
      if (!Stall) done = 1'b1;
    end
    vec++;
    if (!done) begin errs++; $display("FAIL %s timeout got stall=%b exp 0", nm, Stall); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    vec++;
    if ({Stall, MemRE, MemA, InstrF} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      errs++;
      $display("FAIL reset got stall=%b re=%b a=%h instr=%h exp 0 0 0 0", Stall, MemRE, MemA, InstrF);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_cold_miss();
    bit bad_a = 1'b0;
    apply_reset();
    lat = 2;
    fill_line(32'h0000_0104, "cold");
    vec++;
    if (InstrF !== 32'hA1) begin errs++; $display("FAIL cold_instr got %h exp 000000a1", InstrF); end
    vec++;
    if (MemA !== 32'h100 || MemRE !== 1'b0) begin
      bad_a = 1'b1;
      errs++; $display("FAIL cold_mema got a=%h re=%b exp 00000100 0", MemA, MemRE);
    end
  endtask

  task automatic test_same_line();
    logic [31:0] pcs [3] = '{32'h100, 32'h108, 32'h10C};
    logic [31:0] ins [3] = '{32'hA0, 32'hA2, 32'hA3};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i]);
      vec++;
      if ({Stall, MemRE, InstrF} !== {1'b0, 1'b0, ins[i]}) begin
        errs++;
        $display("FAIL same_line pc=%h got stall=%b re=%b instr=%h exp 0 0 %h", pcs[i], Stall, MemRE, InstrF, ins[i]);
      end
    end
  endtask

  task automatic test_conflict();
    fill_line(32'h0000_0200, "conflict_200");
    fill_line(32'h0000_0100, "conflict_100");
  endtask

  task automatic test_mid_fill();
    bit saw300 = 1'b0, done = 1'b0;
    apply_reset();
    lat = 3;
    drive(1'b1, 32'h100);
    for (int i = 0; i < 40 && !done; i++) begin
      drive(1'b1, 32'h300);
      vec++;
      if ({Stall, MemRE, MemA} !== {exp_stall, exp_re, exp_a}) begin
        errs++;
        $display("FAIL mid_fill ctl got stall=%b re=%b a=%h exp %b %b %h", Stall, MemRE, MemA, exp_stall, exp_re, exp_a);
      end
      if (exp_ichk) begin
        vec++;
        if (InstrF !== exp_instr) begin errs++; $display("FAIL mid_fill instr got %h exp %h", InstrF, exp_instr); end
      end
      if (MemRE && MemA == 32'h300) saw300 = 1'b1;
      if (!Stall) done = 1'b1;
    end
    vec++;
    if (!(saw300 && done)) begin errs++; $display("FAIL mid_fill refill got saw300=%b done=%b exp 1 1", saw300, done); end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    resp_en = 1'b0;
    man_mv  = 1'b0;
    drive(1'b1, 32'h100);
    drive(1'b1, 32'h100);
    vec++;
    if ({Stall, MemRE, MemA} !== {1'b1, 1'b1, 32'h100}) begin
      errs++; $display("FAIL rst_fill_enter got stall=%b re=%b a=%h exp 1 1 00000100", Stall, MemRE, MemA);
    end
    #2;
    reset = 1'b0;
    en    = 1'b0;
    #1;
    vec++;
    if ({Stall, MemRE, MemA} !== {1'b0, 1'b0, 32'h0}) begin
      errs++; $display("FAIL rst_async got stall=%b re=%b a=%h exp 0 0 0", Stall, MemRE, MemA);
    end
    model_reset();
    @(negedge clk);
    reset  = 1'b1;
    man_mv = 1'b1;
    drive(1'b0, 32'h100);
    vec++;
    if ({Stall, MemRE, MemA} !== {exp_stall, exp_re, exp_a}) begin
      errs++; $display("FAIL rst_late_valid got stall=%b re=%b a=%h exp %b %b %h", Stall, MemRE, MemA, exp_stall, exp_re, exp_a);
    end
    man_mv  = 1'b0;
    resp_en = 1'b1;
    lat     = 2;
    fill_line(32'h0000_0100, "rst_refill");
  endtask

  task automatic test_random();
    logic [31:0] pc;
    bit e;
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      e  = ($urandom_range(0, 3) != 0);
      drive(e, pc);
      vec++;
      if ({Stall, MemRE, MemA} !== {exp_stall, exp_re, exp_a}) begin
        errs++;
        $display("FAIL rand ctl pc=%h en=%b got stall=%b re=%b a=%h exp %b %b %h", pc, e, Stall, MemRE, MemA, exp_stall, exp_re, exp_a);
      end
      if (exp_ichk) begin
        vec++;
        if (InstrF !== exp_instr) begin errs++; $display("FAIL rand instr pc=%h got %h exp %h", pc, InstrF, exp_instr); end
      end
    end
    rand_lat = 1'b0;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    apply_reset();
    lat = 2;
    fill_line(32'h0000_0104, "stats_fill");
    drive(1'b1, 32'h108);
    drive(1'b1, 32'h10C);
    drive(1'b0, 32'h0);
    vec++;
    if ({MissCnt, HitCnt} !== {32'd1, 32'd3}) begin
      errs++; $display("FAIL stats got miss=%0d hit=%0d exp 1 3", MissCnt, HitCnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line();
    test_conflict();
    test_mid_fill();
    test_reset_mid_fill();
    test_random();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
